program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
- Next-generation program counter for the bus-based CPU.
- Width-parametrised PC with count, absolute jump, PC-relative branch, and a hardware return-address stack for call/return.
- Shares the tri-state system bus with the other CPU modules.
- The PC can drive the bus, and is loaded from the bus for jumps, branches and calls.

Parameters:
- A, 4, PC/bus width in bits.
- D, 4, return-stack depth in entries (1..16).
- SW, $clog2(D+1), stack-pointer width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_  input  1  synchronous active-low reset/clear, sampled on rising clk.
- bus  inout  A  shared system bus.
- ce  input  1  count enable, active high; pc <= pc+1.
- j_  input  1  active-low jump; pc <= bus.
- rel_  input  1  active-low relative mode; with j_ low, pc <= pc + signed(bus).
- call_  input  1  active-low call; push pc+1, then pc <= bus.
- ret_  input  1  active-low return; pc <= popped entry.
- co_  input  1  active-low counter-out; drives pcval onto bus.
- pcval  output  A  current PC value.
- sp  output  SW  stack occupancy, 0..D.
- ovf  output  1  sticky stack-overflow flag.
- unf  output  1  sticky stack-underflow flag.

Behaviour:
- Reset: on a rising clk with clr_=0, set pc=0, sp=0, ovf=0, unf=0. Stack contents are don't-care.
  - Reset overrides every other control in that cycle, including mid-call or mid-return.
- Bus driver is combinational: bus = pcval when co_=0, else all-Z. No clock latency.
- Update priority per rising edge, first match wins, exactly one action per cycle:
  1. clr_=0: reset.
  2. ret_=0:
     - sp>0: pc <= stack[sp-1]; sp <= sp-1.
     - sp==0: pc unchanged, sp stays 0, unf <= 1.
  3. call_=0:
     - sp<D: stack[sp] <= pc+1 (mod 2^A); sp <= sp+1; pc <= bus.
     - sp==D: push discarded, sp stays D, ovf <= 1, pc <= bus (jump still taken).
  4. j_=0, rel_=1: pc <= bus.
  5. j_=0, rel_=0: pc <= pc + sign-extended bus, truncated to A bits. Wraps modulo 2^A in both directions.
  6. ce=1: pc <= pc+1; 2^A-1 wraps to 0.
  7. Otherwise: hold.
- Flag and mode rules:
  - rel_ is ignored unless j_=0.
  - ce is ignored when any higher action fires; it does not add on top of a jump, call or return.
  - ovf and unf are sticky until clr_. They do not block further operation.
- Latency: all effects are visible on pcval/sp one cycle after the enabling edge.
- co_=0 together with j_=0 or call_=0: the PC loads its own value. Legal; no contention inside the block.
- Bus inputs are sampled only when a load/branch/call uses them. Z/X on the bus at other times must not corrupt state.
- Stack storage is a register array; no reset on its contents is required.

Test Plan:
- Reset then count: clr_=0 for one edge, then ce=1 for 17 edges with A=4 → pcval 0,1..15,0,1; sp=0; flags 0.
- Drive and jump: co_=0 at pc=6 → bus=6 same cycle. Then co_=1, bus=5, j_=0, ce=0 for one edge → pcval=5. Release j_, ce=0 → holds 5.
- Relative branch wrap:
  - pc=2, bus=4'b1101 (−3), j_=0, rel_=0 → pcval=15.
  - Then bus=4'b0011 (+3) → pcval=2.
- Call/return nesting (D=4):
  - pc=3, call to 9 → pcval=9, sp=1.
  - At pc=9, call to 12 → pcval=12, sp=2.
  - ret → pcval=10, sp=1; ret → pcval=4, sp=0; unf=0.
- Overflow and underflow:
  - 5 consecutive calls from pc=0, bus=1 each time → sp saturates at 4, ovf=1, pcval=1.
  - 4 rets → sp=0; a 5th ret → pcval unchanged, unf=1.
  - clr_=0 → all flags 0.
- Priority and reset mid-op:
  - ret_=0, call_=0, j_=0, ce=1 same edge with sp=1 → only the pop occurs.
  - clr_=0 asserted with call_=0 → pc=0, sp=0, no push.

Source files
------------

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - width-parametrised PC with jump, relative branch and return-address stack
module program_counter_stack #(
    parameter int A  = 4,
    parameter int D  = 4,
    parameter int SW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          clr_,
    inout  wire  [A-1:0]  bus,
    input  logic          ce,
    input  logic          j_,
    input  logic          rel_,
    input  logic          call_,
    input  logic          ret_,
    input  logic          co_,
    output logic [A-1:0]  pcval,
    output logic [SW-1:0] sp,
    output logic          ovf,
    output logic          unf
);

    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [SW-1:0] SP_FULL = SW'(D);

    logic [A-1:0]  pc;
    logic [A-1:0]  stack [2**IW];
    logic [A-1:0]  pc_inc;
    logic [A-1:0]  pc_rel;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic          stack_full;
    logic          stack_empty;
    logic          do_push;

    // Adding A-bit two's-complement values and truncating to A bits is
    // exactly pc + sign_extend(bus) modulo 2^A.
    assign pc_inc      = pc + A'(1);
    assign pc_rel      = pc + bus;
    assign push_idx    = IW'(sp);
    assign pop_idx     = IW'(sp - SW'(1));
    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign do_push     = clr_ && ret_ && !call_ && !stack_full;

    assign pcval = pc;
    assign bus   = co_ ? {A{1'bz}} : pc;

    always_ff @(posedge clk) begin
        if (!clr_) begin
            pc  <= '0;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (!ret_) begin
            if (!stack_empty) begin
                pc <= stack[pop_idx];
                sp <= sp - SW'(1);
            end else begin
                unf <= 1'b1;
            end
        end else if (!call_) begin
            // The jump is taken even when the push has to be discarded.
            pc <= bus;
            if (!stack_full) begin
                sp <= sp + SW'(1);
            end else begin
                ovf <= 1'b1;
            end
        end else if (!j_) begin
            pc <= rel_ ? bus : pc_rel;
        end else if (ce) begin
            pc <= pc_inc;
        end
    end

    // Return-address storage carries no reset; only sp says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - scoreboard bench for program_counter_stack
module tb_program_counter_stack;

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        bit         chk_bus;
        logic [3:0] bus_exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_ = 1'b0;
    logic       ce = 1'b0;
    logic       j_ = 1'b1;
    logic       rel_ = 1'b1;
    logic       call_ = 1'b1;
    logic       ret_ = 1'b1;
    logic       co_ = 1'b1;
    logic       tb_drv = 1'b0;
    logic [3:0] tb_bus = '0;
    wire  [3:0] bus;
    logic [3:0] pcval;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign bus = tb_drv ? tb_bus : 4'bzzzz;

    program_counter_stack #(.A(4), .D(4)) dut (
        .clk   (clk),
        .clr_  (clr_),
        .bus   (bus),
        .ce    (ce),
        .j_    (j_),
        .rel_  (rel_),
        .call_ (call_),
        .ret_  (ret_),
        .co_   (co_),
        .pcval (pcval),
        .sp    (sp),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    // Monitor: every queued expectation describes the state visible now.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pcval !== e.pc || sp !== e.sp || ovf !== e.ovf || unf !== e.unf ||
                (e.chk_bus && bus !== e.bus_exp)) begin
                errors++;
                $display("FAIL %s: got pc=%0d sp=%0d ovf=%b unf=%b bus=%h, expected pc=%0d sp=%0d ovf=%b unf=%b bus=%h",
                         e.name, pcval, sp, ovf, unf, bus, e.pc, e.sp, e.ovf, e.unf,
                         e.chk_bus ? e.bus_exp : bus);
            end
        end
    end

    task automatic push_exp(input string name, input logic [3:0] p, input logic [2:0] s,
                            input logic o, input logic u, input bit cb, input logic [3:0] be);
        exp_t e;
        e.name = name; e.pc = p; e.sp = s; e.ovf = o; e.unf = u;
        e.chk_bus = cb; e.bus_exp = be;
        exp_q.push_back(e);
    endtask

    // Flags are active-high "assert this control"; the task maps them to pins.
    task automatic cyc(input string name, input bit a_clr, input bit a_ret, input bit a_call,
                       input bit a_j, input bit a_rel, input bit a_ce, input logic [3:0] b,
                       input logic [3:0] e_pc, input logic [2:0] e_sp, input logic e_ovf,
                       input logic e_unf);
        clr_   = !a_clr;
        ret_   = !a_ret;
        call_  = !a_call;
        j_     = !a_j;
        rel_   = !a_rel;
        ce     = a_ce;
        co_    = 1'b1;
        tb_bus = b;
        tb_drv = a_j || a_call;
        @(posedge clk);
        #1;
        push_exp(name, e_pc, e_sp, e_ovf, e_unf, 1'b0, 4'h0);
        clr_ = 1'b1; ret_ = 1'b1; call_ = 1'b1; j_ = 1'b1; rel_ = 1'b1; ce = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic peek_bus(input string name, input logic [3:0] e_pc, input logic [2:0] e_sp,
                            input logic e_ovf, input logic e_unf);
        tb_drv = 1'b0;
        co_    = 1'b0;
        push_exp(name, e_pc, e_sp, e_ovf, e_unf, 1'b1, e_pc);
        @(negedge clk);
        #1;
        co_ = 1'b1;
    endtask

    initial begin
        //   name         clr ret cal j  rel ce  bus   pc  sp ovf unf
        cyc("reset",      1, 0, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 0);
        for (int i = 1; i <= 17; i++)
            cyc("count",  0, 0, 0, 0, 0, 1, 4'h0, 4'(i % 16), 3'd0, 0, 0);
        cyc("jump6",      0, 0, 0, 1, 0, 0, 4'h6, 4'd6, 3'd0, 0, 0);
        peek_bus("drive6",                        4'd6, 3'd0, 0, 0);
        cyc("jump5",      0, 0, 0, 1, 0, 0, 4'h5, 4'd5, 3'd0, 0, 0);
        cyc("hold5",      0, 0, 0, 0, 0, 0, 4'h0, 4'd5, 3'd0, 0, 0);
        cyc("jump2",      0, 0, 0, 1, 0, 0, 4'h2, 4'd2, 3'd0, 0, 0);
        cyc("rel_m3",     0, 0, 0, 1, 1, 0, 4'hd, 4'd15, 3'd0, 0, 0);
        cyc("rel_p3",     0, 0, 0, 1, 1, 0, 4'h3, 4'd2, 3'd0, 0, 0);
        cyc("jump3",      0, 0, 0, 1, 0, 0, 4'h3, 4'd3, 3'd0, 0, 0);
        cyc("call9",      0, 0, 1, 0, 0, 0, 4'h9, 4'd9, 3'd1, 0, 0);
        cyc("call12",     0, 0, 1, 0, 0, 0, 4'hc, 4'd12, 3'd2, 0, 0);
        cyc("ret10",      0, 1, 0, 0, 0, 0, 4'h0, 4'd10, 3'd1, 0, 0);
        cyc("ret4",       0, 1, 0, 0, 0, 0, 4'h0, 4'd4, 3'd0, 0, 0);
        cyc("jump0",      0, 0, 0, 1, 0, 0, 4'h0, 4'd0, 3'd0, 0, 0);
        cyc("ovf_c1",     0, 0, 1, 0, 0, 0, 4'h1, 4'd1, 3'd1, 0, 0);
        cyc("ovf_c2",     0, 0, 1, 0, 0, 0, 4'h1, 4'd1, 3'd2, 0, 0);
        cyc("ovf_c3",     0, 0, 1, 0, 0, 0, 4'h1, 4'd1, 3'd3, 0, 0);
        cyc("ovf_c4",     0, 0, 1, 0, 0, 0, 4'h1, 4'd1, 3'd4, 0, 0);
        cyc("ovf_c5",     0, 0, 1, 0, 0, 0, 4'h1, 4'd1, 3'd4, 1, 0);
        cyc("unf_r1",     0, 1, 0, 0, 0, 0, 4'h0, 4'd2, 3'd3, 1, 0);
        cyc("unf_r2",     0, 1, 0, 0, 0, 0, 4'h0, 4'd2, 3'd2, 1, 0);
        cyc("unf_r3",     0, 1, 0, 0, 0, 0, 4'h0, 4'd2, 3'd1, 1, 0);
        cyc("unf_r4",     0, 1, 0, 0, 0, 0, 4'h0, 4'd1, 3'd0, 1, 0);
        cyc("unf_r5",     0, 1, 0, 0, 0, 0, 4'h0, 4'd1, 3'd0, 1, 1);
        cyc("sticky_ce",  0, 0, 0, 0, 0, 1, 4'h0, 4'd2, 3'd0, 1, 1);
        cyc("clr_flags",  1, 0, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 0);
        cyc("jump7",      0, 0, 0, 1, 0, 0, 4'h7, 4'd7, 3'd0, 0, 0);
        cyc("call3",      0, 0, 1, 0, 0, 0, 4'h3, 4'd3, 3'd1, 0, 0);
        cyc("prio_ret",   0, 1, 1, 1, 0, 1, 4'h9, 4'd8, 3'd0, 0, 0);
        cyc("j_over_ce",  0, 0, 0, 1, 0, 1, 4'h5, 4'd5, 3'd0, 0, 0);
        cyc("rel_no_j",   0, 0, 0, 0, 1, 1, 4'h0, 4'd6, 3'd0, 0, 0);
        cyc("z_hold",     0, 0, 0, 0, 0, 0, 4'h0, 4'd6, 3'd0, 0, 0);
        cyc("clr_call",   1, 0, 1, 0, 0, 0, 4'h9, 4'd0, 3'd0, 0, 0);
        cyc("no_push",    0, 1, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 1);
        cyc("clr2",       1, 0, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 0);
        cyc("call4",      0, 0, 1, 0, 0, 0, 4'h4, 4'd4, 3'd1, 0, 0);
        cyc("clr_ret",    1, 1, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 0);
        cyc("empty_ret",  0, 1, 0, 0, 0, 0, 4'h0, 4'd0, 3'd0, 0, 1);

        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
